// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for sram_port_arbiter: the request handshake and
// the read-response channel for both requesters. Requesters drive the
// master modport; the arbiter takes the slave modport.
interface sram_port_arbiter_if #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 11
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_write;
    logic [W_ADDR-1:0]     req0_addr;
    logic [W_DATA-1:0]     req0_wdata;
    logic [W_DATA/8-1:0]   req0_wmask;
    logic                  rsp0_valid;
    logic [W_DATA-1:0]     rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_write;
    logic [W_ADDR-1:0]     req1_addr;
    logic [W_DATA-1:0]     req1_wdata;
    logic [W_DATA/8-1:0]   req1_wmask;
    logic                  rsp1_valid;
    logic [W_DATA-1:0]     rsp1_rdata;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_wmask,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_wmask,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_wmask,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_wmask,
        output req1_ready, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of one byte-enabled synchronous SRAM with
// a 1-cycle read latency. One access is granted per cycle; read data comes
// back to the requester that issued the read one cycle after acceptance and
// is held until the next response for that requester.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise requester 0 has fixed priority.
module sram_port_arbiter #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_arbiter_if.slave    bus,
    output logic [W_ADDR-1:0]     sram_addr,
    output logic [W_DATA-1:0]     sram_wdata,
    output logic [W_DATA/8-1:0]   sram_wen,
    input  logic [W_DATA-1:0]     sram_rdata
);
    localparam int W_MASK = W_DATA / 8;

    logic              gnt0;
    logic              gnt1;
    logic              rd0_vld_p1;
    logic              rd1_vld_p1;
    logic [W_DATA-1:0] held0_p1;
    logic [W_DATA-1:0] held1_p1;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Preferred requester on a tie; flips to the loser after every grant.
    logic ptr_p1;

    // Round-robin grant: the preferred requester wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.req0_valid && (!bus.req1_valid || !ptr_p1))
                gnt0 = 1'b1;
            else if (bus.req1_valid)
                gnt1 = 1'b1;
        end
    end

    // Point at the requester that was not granted this cycle.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_p1 <= 1'b0;
        else if (gnt0)
            ptr_p1 <= 1'b1;
        else if (gnt1)
            ptr_p1 <= 1'b0;
    end
`else
    // Fixed priority grant: requester 0 always wins, requester 1 may starve.
    always_comb begin
        gnt0 = !rst && bus.req0_valid;
        gnt1 = !rst && bus.req1_valid && !bus.req0_valid;
    end
`endif

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // SRAM request side: address/data follow requester 1 only when it holds
    // the grant, so idle cycles present requester 0's address.
    always_comb begin
        sram_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
        sram_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
        sram_wen   = '0;
        if (gnt0 && bus.req0_write)
            sram_wen = bus.req0_wmask;
        else if (gnt1 && bus.req1_write)
            sram_wen = bus.req1_wmask;
    end

    // ---- p0 -> p1: remember which requester owns the read in flight ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_vld_p1 <= 1'b0;
            rd1_vld_p1 <= 1'b0;
        end else begin
            rd0_vld_p1 <= gnt0 && !bus.req0_write;
            rd1_vld_p1 <= gnt1 && !bus.req1_write;
        end
    end

    assign bus.rsp0_valid = rd0_vld_p1 && !rst;
    assign bus.rsp1_valid = rd1_vld_p1 && !rst;

    // Capture each delivered read so it stays visible between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            held0_p1 <= '0;
            held1_p1 <= '0;
        end else begin
            if (bus.rsp0_valid)
                held0_p1 <= sram_rdata;
            if (bus.rsp1_valid)
                held1_p1 <= sram_rdata;
        end
    end

    // Response data: live SRAM output on the delivery cycle, held value after.
    always_comb begin
        if (rst) begin
            bus.rsp0_rdata = '0;
            bus.rsp1_rdata = '0;
        end else begin
            bus.rsp0_rdata = bus.rsp0_valid ? sram_rdata : held0_p1;
            bus.rsp1_rdata = bus.rsp1_valid ? sram_rdata : held1_p1;
        end
    end

    logic unused_mask_w;
    assign unused_mask_w = (W_MASK == 0);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized + directed bench for sram_port_arbiter with a behavioural
// reference model (memory image, arbitration rule, expected responses).
module tb_sram_port_arbiter;
    localparam int W_DATA = 32;
    localparam int W_ADDR = 11;
    localparam int W_MASK = W_DATA / 8;
    localparam int DEPTH  = 1 << W_ADDR;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) bus ();

    logic [W_ADDR-1:0] sram_addr;
    logic [W_DATA-1:0] sram_wdata;
    logic [W_MASK-1:0] sram_wen;
    logic [W_DATA-1:0] sram_rdata;

    sram_port_arbiter #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_wen   (sram_wen),
        .sram_rdata (sram_rdata)
    );

    // SRAM array attached to the arbiter
    logic              init_mem;
    logic [W_DATA-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= '0;
        end else begin
            for (int b = 0; b < W_MASK; b++)
                if (sram_wen[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        sram_rdata <= sram_mem[sram_addr];
    end

    // Reference model state
    logic [W_DATA-1:0] ref_mem [DEPTH];
    bit                ptr;
    bit                exp_vld  [2];
    logic [W_DATA-1:0] exp_data [2];
    logic [W_DATA-1:0] held     [2];

    // Stimulus for the current cycle
    bit                v [2];
    bit                w [2];
    logic [W_ADDR-1:0] a [2];
    logic [W_DATA-1:0] d [2];
    logic [W_MASK-1:0] m [2];

    // Outputs sampled in the last step
    bit                s_ready [2];
    bit                s_vld   [2];
    logic [W_DATA-1:0] s_rdata [2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle();
        for (int n = 0; n < 2; n++) begin
            v[n] = 0; w[n] = 0; a[n] = '0; d[n] = '0; m[n] = '0;
        end
    endtask

    task automatic req(input int n, input bit wr, input logic [W_ADDR-1:0] ad,
                       input logic [W_DATA-1:0] dt, input logic [W_MASK-1:0] mk);
        v[n] = 1; w[n] = wr; a[n] = ad; d[n] = dt; m[n] = mk;
    endtask

    function automatic logic [W_DATA-1:0] merge(input logic [W_DATA-1:0] old,
                                                input logic [W_DATA-1:0] nw,
                                                input logic [W_MASK-1:0] mk);
        logic [W_DATA-1:0] r;
        r = old;
        for (int b = 0; b < W_MASK; b++)
            if (mk[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One clock cycle: drive, compare against the model at negedge, advance model.
    task automatic step(input bit r);
        bit g [2];
        bit ev;
        logic [W_MASK-1:0] e_wen;
        logic [W_DATA-1:0] e_rd;
        logic [W_DATA-1:0] obs_rd;
        bit obs_vld;

        rst = r;
        bus.req0_valid = v[0]; bus.req0_write = w[0]; bus.req0_addr = a[0];
        bus.req0_wdata = d[0]; bus.req0_wmask = m[0];
        bus.req1_valid = v[1]; bus.req1_write = w[1]; bus.req1_addr = a[1];
        bus.req1_wdata = d[1]; bus.req1_wmask = m[1];
        @(negedge clk);

        if (r) begin
            g[0] = 0; g[1] = 0;
        end else begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            if (v[0] && v[1]) begin
                g[0] = (ptr == 0); g[1] = (ptr == 1);
            end else begin
                g[0] = v[0]; g[1] = v[1];
            end
`else
            g[0] = v[0]; g[1] = v[1] && !v[0];
`endif
        end

        check_eq("req0_ready", bus.req0_ready, g[0]);
        check_eq("req1_ready", bus.req1_ready, g[1]);
        e_wen = (g[0] && w[0]) ? m[0] : (g[1] && w[1]) ? m[1] : '0;
        check_eq("sram_wen", sram_wen, e_wen);
        check_eq("sram_addr", sram_addr, g[1] ? a[1] : a[0]);
        if (e_wen != 0) check_eq("sram_wdata", sram_wdata, g[1] ? d[1] : d[0]);

        for (int n = 0; n < 2; n++) begin
            ev   = r ? 1'b0 : exp_vld[n];
            e_rd = r ? '0 : (ev ? exp_data[n] : held[n]);
            obs_vld = (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
            obs_rd  = (n == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
            check_eq(n == 0 ? "rsp0_valid" : "rsp1_valid", obs_vld, ev);
            check_eq(n == 0 ? "rsp0_rdata" : "rsp1_rdata", obs_rd, e_rd);
            s_vld[n]   = obs_vld;
            s_rdata[n] = obs_rd;
            if (r) held[n] = '0;
            else if (ev) held[n] = exp_data[n];
        end
        s_ready[0] = bus.req0_ready;
        s_ready[1] = bus.req1_ready;

        for (int n = 0; n < 2; n++) begin
            exp_vld[n]  = g[n] && !w[n];
            exp_data[n] = ref_mem[a[n]];
        end
        for (int n = 0; n < 2; n++)
            if (g[n] && w[n]) ref_mem[a[n]] = merge(ref_mem[a[n]], d[n], m[n]);
        if (r) ptr = 0;
        else if (g[0]) ptr = 1;
        else if (g[1]) ptr = 0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ptr = 0;
        for (int n = 0; n < 2; n++) begin
            exp_vld[n] = 0; exp_data[n] = '0; held[n] = '0;
        end
        idle();
        init_mem = 1'b1;
        @(posedge clk);
        #1;
        step(1);
        init_mem = 1'b0;
        step(1);

        // Write then read back through requester 0
        req(0, 1, 11'h010, 32'hDEADBEEF, 4'hF); step(0);
        idle(); req(0, 0, 11'h010, '0, '0); step(0);
        idle(); step(0);
        check_eq("dir_rsp0_valid", s_vld[0], 1);
        check_eq("dir_rsp0_deadbeef", s_rdata[0], 32'hDEADBEEF);

        // Partial byte write from requester 1
        req(1, 1, 11'h005, 32'h11223344, 4'h2); step(0);
        idle(); req(1, 0, 11'h005, '0, '0); step(0);
        idle(); step(0);
        check_eq("dir_rsp1_bytemask", s_rdata[1], 32'h00003300);
        check_eq("dir_rsp0_quiet", s_vld[0], 0);

        // Held data across idle cycles
        req(0, 1, 11'h020, 32'hA5A5A5A5, 4'hF); step(0);
        idle(); req(0, 0, 11'h020, '0, '0); step(0);
        idle(); step(0);
        for (int i = 0; i < 3; i++) begin
            step(0);
            check_eq("dir_hold_valid", s_vld[0], 0);
            check_eq("dir_hold_rdata", s_rdata[0], 32'hA5A5A5A5);
        end

        // Back-to-back write/read at the top address
        req(0, 1, 11'h7FF, 32'h0000CAFE, 4'hF); step(0);
        idle(); req(0, 0, 11'h7FF, '0, '0); step(0);
        idle(); step(0);
        check_eq("dir_b2b_valid", s_vld[0], 1);
        check_eq("dir_b2b_rdata", s_rdata[0], 32'h0000CAFE);

        // Contention: both requesters read for 6 cycles after reset
        idle(); step(1);
        for (int i = 0; i < 6; i++) begin
            idle(); req(0, 0, 11'h010, '0, '0); req(1, 0, 11'h005, '0, '0);
            step(0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            check_eq("dir_rr_gnt0", s_ready[0], (i % 2) == 0);
            check_eq("dir_rr_gnt1", s_ready[1], (i % 2) == 1);
`else
            check_eq("dir_fp_gnt0", s_ready[0], 1);
            check_eq("dir_fp_gnt1", s_ready[1], 0);
`endif
        end
        idle(); step(0);

        // Read during reset is discarded; pointer returns to requester 0
        req(0, 0, 11'h020, '0, '0); step(0);
        req(0, 0, 11'h020, '0, '0); req(1, 0, 11'h010, '0, '0); step(1);
        idle(); step(0);
        check_eq("dir_rst_rsp0", s_vld[0], 0);
        check_eq("dir_rst_rsp1", s_vld[1], 0);
        req(0, 0, 11'h020, '0, '0); req(1, 0, 11'h010, '0, '0); step(0);
        check_eq("dir_rst_ptr", s_ready[0], 1);
        idle(); step(0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                v[n] = $urandom_range(0, 3) != 0;
                w[n] = $urandom_range(0, 1) != 0;
                a[n] = W_ADDR'($urandom_range(0, 15));
                d[n] = $urandom;
                m[n] = W_MASK'($urandom_range(0, 15));
            end
            step($urandom_range(0, 49) == 0);
        end
        idle(); step(0);
        step(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter W_DATA, default 32, SRAM word width in bits (multiple of 8).
REQ-002 SHALL have parameter W_ADDR, default 11, SRAM word address width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports reqN_valid, input, 1, requester N (N = 0, 1) presents an access.
REQ-006 SHALL have ports reqN_ready, output, 1, requester N's access is accepted this cycle.
REQ-007 SHALL have ports reqN_write, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have ports reqN_addr, input, W_ADDR, word address.
REQ-009 SHALL have ports reqN_wdata, input, W_DATA, write data.
REQ-010 SHALL have ports reqN_wmask, input, W_DATA/8, per-byte write enable.
REQ-011 SHALL have ports rspN_valid, output, 1, read data for requester N is on rspN_rdata this cycle.
REQ-012 SHALL have ports rspN_rdata, output, W_DATA, read data.
REQ-013 SHALL have ports sram_addr, output, W_ADDR; sram_wdata, output, W_DATA; sram_wen, output, W_DATA/8; sram_rdata, input, W_DATA, driving one byte-enabled synchronous SRAM with 1-cycle read latency.

Function
REQ-014 SHALL grant at most one requester per cycle; reqN_ready = reqN_valid AND granted, combinational from current inputs and state.
REQ-015 SHALL drive sram_addr/sram_wdata from the granted requester in the same cycle; sram_wen = reqN_wmask for a granted write, all-zero otherwise, including idle cycles.
REQ-016 SHALL, with no grant, drive sram_addr from requester 0 and sram_wen = 0.
REQ-017 SHALL assert rspN_valid for exactly one cycle, exactly one cycle after a read accepted from requester N; writes produce no response.
REQ-018 SHALL present rspN_rdata = sram_rdata while rspN_valid is high, and hold the last delivered value otherwise.
REQ-019 SHALL sustain one access per cycle with back-to-back grants, and need no idle cycles between reads and writes.
REQ-020 SHALL treat a read following a write to the same address in the next cycle as returning the newly written data.
REQ-021 SHALL not require requesters to hold valid stable; a deasserted valid withdraws the request with no side effects.

Reset
REQ-022 SHALL, while rst is high, force rsp0_valid = rsp1_valid = 0, held read data = 0, and the priority pointer to requester 0.
REQ-023 SHALL, while rst is high, force req0_ready = req1_ready = 0 and sram_wen = 0.
REQ-024 SHALL discard a read accepted in the cycle rst is asserted: no rspN_valid follows.

Configuration
REQ-025 SHALL support macro SRAM_ARB_ROUND_ROBIN_EN.
REQ-026 SHALL, with SRAM_ARB_ROUND_ROBIN_EN defined, arbitrate round-robin:
- 1-bit pointer names the preferred requester.
- After any grant, the pointer points to the non-granted requester.
- On simultaneous requests, the preferred requester wins.
REQ-027 SHALL, with SRAM_ARB_ROUND_ROBIN_EN undefined, arbitrate with fixed priority: requester 0 always wins, the pointer is absent, and requester 1 may starve.

Verification
REQ-028 SHALL cover: after reset, a write of 0xDEADBEEF, mask 0xF, to address 0x010 from requester 0, then a read of 0x010 -> rsp0_valid one cycle after acceptance, rsp0_rdata = 0xDEADBEEF.
REQ-029 SHALL cover: a write of 0x11223344, mask 0x2, over 0x00000000 at address 0x005 from requester 1, then a read -> rsp1_rdata = 0x00003300, rsp0_valid stays 0.
REQ-030 SHALL cover: both requesters hold valid reads for 6 cycles -> with the macro, grants alternate 0,1,0,1,0,1; without it, requester 0 is granted all 6 and req1_ready stays 0.
REQ-031 SHALL cover: read from requester 0 at address 0x020 (contents 0xA5A5A5A5), then 3 idle cycles -> rsp0_rdata holds 0xA5A5A5A5 while rsp0_valid = 0.
REQ-032 SHALL cover: read accepted in cycle T with rst high in T -> rsp0_valid and rsp1_valid = 0 in T+1, pointer = 0.
REQ-033 SHALL cover: back-to-back write of 0x0000CAFE to address 0x7FF in cycle T and read of 0x7FF in T+1 from the same requester -> response in T+2 = 0x0000CAFE, with no idle cycle inserted.
